bar_move_scheduler: RTL and testbench
=====================================

Name: bar_move_scheduler

Overview:
Sequences paddle-move updates for two paddle drawers (left and right player) from Nios II custom-instruction requests. It holds one pending move per player and merges repeated requests. On each frame-start pulse it grants pending moves round-robin and issues one single-cycle update strobe, with incDec/coordY, per paddle drawer. It sits between the custom-instruction decode and the two paddle drawers, so paddles move at most once per frame and never mid-scan.

Parameters:
STEP_W, 9, width of step/coordY (matches the 9-bit y axis)
MAX_STEP, 40, saturation limit for merged steps
SETTLE_CYCLES, 4, idle cycles after each issued strobe before the next grant
GRANTS_PER_FRAME, 2, maximum strobes issued per frame_start

Ports:
clk_in  in  1  base clock from the board
i_rst  in  1  synchronous, active-high reset
req_valid  in  1  custom-instruction move request strobe (clk_en qualified upstream)
req_player  in  1  0 = left paddle, 1 = right paddle
req_incDec  in  1  1 = move down (increment y), 0 = move up
req_step  in  STEP_W  step magnitude; 0 is ignored
frame_start  in  1  one-cycle pulse at start of vertical blanking
bar_strobe  out  2  one-hot; drives the selected paddle drawer's clk_en and refreshBar
bar_incDec  out  1  direction for the strobed paddle
bar_coordY  out  STEP_W  step for the strobed paddle
pending  out  2  per-player pending flag
busy  out  1  high outside IDLE

Behaviour:
- Reset: all outputs 0; pending slots cleared; rr_ptr=0; FSM=IDLE; grant count=0. Reset mid-operation aborts with no strobe in the reset cycle or after it.
- Slot update on req_valid with req_step!=0, where slot=req_player:
  - Slot empty: store dir/step and set pending.
  - Same direction: step = min(step+req_step, MAX_STEP), with the sum computed at STEP_W+1 bits.
  - Opposite direction: replace dir/step.
- req_step==0: no effect.
- FSM states: IDLE, ARB, ISSUE, SETTLE.
  - IDLE: on frame_start, grant count=0. Go to ARB if any pending, else stay in IDLE.
  - ARB (1 cycle): pick the pending player starting at rr_ptr and latch its dir/step into the output regs. Clear that slot. rr_ptr = winner^1. If none pending, go to IDLE.
  - ISSUE (1 cycle): bar_strobe[winner]=1 with bar_incDec/bar_coordY valid the same cycle. Increment grant count. Go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles with bar_strobe=0. Then go to ARB if any pending and grant count<GRANTS_PER_FRAME, else IDLE.
- Latency: frame_start at cycle t gives ARB at t+1 and strobe at t+2.
- bar_incDec/bar_coordY hold their last value outside ISSUE.
- frame_start while busy: ignored (no restart, no count reset).
- req_valid in the same cycle as ARB clearing that player's slot: the new request is written into the cleared slot (clear first, then new write). It stays pending for the next grant or frame.
- A request for a player already served this frame waits for the next frame_start (cap GRANTS_PER_FRAME).
- Range clamping stays in the paddle drawer; this block never inspects y position.

Optional Feature:
MOVE_STATS_EN
- Defined: adds two 16-bit wrapping counters, issued_cnt[0..1], incremented in ISSUE for the winner, plus merged_cnt (16-bit, wrapping), incremented on every same-direction merge or opposite-direction replace. All counters reset to 0 on i_rst. Exposed on outputs issued_cnt0, issued_cnt1, merged_cnt.
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Shared package pong_pkg: FSM state enum, STEP_W, player index constants (PLAYER_L=0, PLAYER_R=1), MAX_STEP default.
- One sub-module, move_slot: one instance per player. Holds the pending flag, dir and step, and applies the merge/replace/clear rules including same-cycle clear+write.

Test Plan:
- Reset, then req(player0, down, 10), then frame_start at t: bar_strobe=01 at t+2, bar_incDec=1, bar_coordY=10; pending=00 afterwards.
- req(p0, down, 30) then req(p0, down, 25), then frame_start: single strobe with coordY=40 (saturated at MAX_STEP).
- req(p1, up, 5) then req(p1, down, 7), then frame_start: bar_strobe=10, bar_incDec=1, coordY=7.
- Both players pending, rr_ptr=0: strobe 01 at t+2, strobe 10 at t+2+SETTLE_CYCLES+2=t+8. The next frame with both pending starts with 01 again, since rr_ptr returned to 0 after the second grant.
- With GRANTS_PER_FRAME=1 and both pending: one strobe per frame; player1 is served on the following frame_start; a frame_start during SETTLE is ignored.
- i_rst asserted in SETTLE with p1 pending: next cycle busy=0, pending=00, bar_strobe=00; a later frame_start produces no strobe.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the paddle move scheduler.
package pong_pkg;

  localparam int unsigned STEP_W       = 9;
  localparam int unsigned MAX_STEP_DEF = 40;

  localparam logic PLAYER_L = 1'b0;
  localparam logic PLAYER_R = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_SETTLE
  } state_t;

  typedef struct packed {
    logic              dir;
    logic [STEP_W-1:0] step;
  } move_t;

endpackage

// File: rtl/bar_move_scheduler_move_slot.sv
// One pending paddle move: merges same-direction requests with saturation,
// replaces on direction change, and lets a same-cycle write win over a clear.
module move_slot
  import pong_pkg::*;
#(
  parameter int unsigned MAX_STEP = MAX_STEP_DEF
) (
  input  logic  clk_in,
  input  logic  i_rst,
  input  logic  wr,
  input  move_t wr_mv,
  input  logic  clr,
  output logic  valid,
  output move_t mv
);

  localparam int unsigned SUM_W = STEP_W + 1;

  logic [SUM_W-1:0]  sum_c;
  logic [STEP_W-1:0] merged_c;

  always_comb begin
    sum_c    = {1'b0, mv.step} + {1'b0, wr_mv.step};
    merged_c = (sum_c > SUM_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : sum_c[STEP_W-1:0];
  end

  // A slot being cleared this cycle counts as empty for an incoming write.
  always_ff @(posedge clk_in) begin
    if (i_rst) begin
      valid <= 1'b0;
      mv    <= '0;
    end else if (wr) begin
      valid <= 1'b1;
      if (!valid || clr || (mv.dir != wr_mv.dir)) begin
        mv <= wr_mv;
      end else begin
        mv.step <= merged_c;
      end
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bar_move_scheduler.sv
// Per-frame round-robin scheduler of paddle move strobes for two paddle drawers.
// Optional MOVE_STATS_EN adds issued/merged event counters.
module bar_move_scheduler
  import pong_pkg::*;
#(
  parameter int unsigned MAX_STEP         = MAX_STEP_DEF,
  parameter int unsigned SETTLE_CYCLES    = 4,
  parameter int unsigned GRANTS_PER_FRAME = 2
) (
  input  logic              clk_in,
  input  logic              i_rst,
  input  logic              req_valid,
  input  logic              req_player,
  input  logic              req_incDec,
  input  logic [STEP_W-1:0] req_step,
  input  logic              frame_start,
  output logic [1:0]        bar_strobe,
  output logic              bar_incDec,
  output logic [STEP_W-1:0] bar_coordY,
  output logic [1:0]        pending,
  output logic              busy
`ifdef MOVE_STATS_EN
  ,
  output logic [15:0]       issued_cnt0,
  output logic [15:0]       issued_cnt1,
  output logic [15:0]       merged_cnt
`endif
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned GW = $clog2(GRANTS_PER_FRAME + 1);

  state_t        state_q, state_d;
  logic          rr_q;
  logic [SW-1:0] settle_q;
  logic [GW-1:0] grant_q;
  logic [1:0]    strobe_q;
  logic          busy_q;

  logic [1:0]    req_wr;
  move_t         req_mv;
  logic [1:0]    slot_valid;
  move_t         slot_mv [2];
  logic [1:0]    slot_clr;
  logic          any_pend;
  logic          settle_done;
  logic          winner_c;
  logic          arb_fire_c;
  logic [1:0]    strobe_d;

  assign req_mv.dir  = req_incDec;
  assign req_mv.step = req_step;
  assign any_pend    = |slot_valid;
  assign settle_done = (settle_q == SW'(SETTLE_CYCLES - 1));

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req_wr[i] = req_valid && (req_step != '0) && (req_player == 1'(i));
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_slot
    move_slot #(.MAX_STEP(MAX_STEP)) u_slot (
      .clk_in (clk_in),
      .i_rst  (i_rst),
      .wr     (req_wr[g]),
      .wr_mv  (req_mv),
      .clr    (slot_clr[g]),
      .valid  (slot_valid[g]),
      .mv     (slot_mv[g])
    );
  end

  always_ff @(posedge clk_in) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (frame_start && any_pend) state_d = ST_ARB;
      ST_ARB:    state_d = any_pend ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:  state_d = ST_SETTLE;
      ST_SETTLE: if (settle_done) begin
        state_d = (any_pend && (grant_q < GW'(GRANTS_PER_FRAME))) ? ST_ARB : ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Arbitration result and next values of the registered outputs.
  always_comb begin
    winner_c   = slot_valid[rr_q] ? rr_q : ~rr_q;
    arb_fire_c = (state_q == ST_ARB) && any_pend;
    slot_clr   = 2'b00;
    strobe_d   = 2'b00;
    if (arb_fire_c) begin
      slot_clr = (winner_c == PLAYER_R) ? 2'b10 : 2'b01;
      strobe_d = slot_clr;
    end
  end

  always_ff @(posedge clk_in) begin
    if (i_rst) begin
      strobe_q   <= 2'b00;
      busy_q     <= 1'b0;
      bar_incDec <= 1'b0;
      bar_coordY <= '0;
      rr_q       <= PLAYER_L;
      grant_q    <= '0;
      settle_q   <= '0;
    end else begin
      strobe_q <= strobe_d;
      busy_q   <= (state_d != ST_IDLE);
      if (arb_fire_c) begin
        bar_incDec <= slot_mv[winner_c].dir;
        bar_coordY <= slot_mv[winner_c].step;
        rr_q       <= ~winner_c;
      end
      if ((state_q == ST_IDLE) && frame_start) grant_q <= '0;
      else if (state_q == ST_ISSUE)            grant_q <= grant_q + GW'(1);
      if (state_q == ST_ISSUE)       settle_q <= '0;
      else if (state_q == ST_SETTLE) settle_q <= settle_q + SW'(1);
    end
  end

  // A reset asserted while a strobe is up suppresses it in that same cycle.
  assign bar_strobe = strobe_q & {2{~i_rst}};
  assign busy       = busy_q;
  assign pending    = slot_valid;

`ifdef MOVE_STATS_EN
  logic merge_c;
  assign merge_c = |(req_wr & slot_valid & ~slot_clr);

  always_ff @(posedge clk_in) begin
    if (i_rst) begin
      issued_cnt0 <= '0;
      issued_cnt1 <= '0;
      merged_cnt  <= '0;
    end else begin
      if (strobe_q[0]) issued_cnt0 <= issued_cnt0 + 16'd1;
      if (strobe_q[1]) issued_cnt1 <= issued_cnt1 + 16'd1;
      if (merge_c)     merged_cnt  <= merged_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bar_move_scheduler.sv
// Directed self-checking bench: default instance plus a one-grant-per-frame instance.
module tb_bar_move_scheduler;
  import pong_pkg::*;

  logic              clk_in = 1'b0;
  logic              i_rst;
  logic              req_valid;
  logic              req_player;
  logic              req_incDec;
  logic [STEP_W-1:0] req_step;
  logic              frame_start;

  logic [1:0]        bar_strobe, bar_strobe1;
  logic              bar_incDec, bar_incDec1;
  logic [STEP_W-1:0] bar_coordY, bar_coordY1;
  logic [1:0]        pending, pending1;
  logic              busy, busy1;
`ifdef MOVE_STATS_EN
  logic [15:0]       issued_cnt0, issued_cnt1, merged_cnt;
  logic [15:0]       issued_cnt0_b, issued_cnt1_b, merged_cnt_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  bar_move_scheduler dut (
    .clk_in      (clk_in),
    .i_rst       (i_rst),
    .req_valid   (req_valid),
    .req_player  (req_player),
    .req_incDec  (req_incDec),
    .req_step    (req_step),
    .frame_start (frame_start),
    .bar_strobe  (bar_strobe),
    .bar_incDec  (bar_incDec),
    .bar_coordY  (bar_coordY),
    .pending     (pending),
    .busy        (busy)
`ifdef MOVE_STATS_EN
    ,
    .issued_cnt0 (issued_cnt0),
    .issued_cnt1 (issued_cnt1),
    .merged_cnt  (merged_cnt)
`endif
  );

  bar_move_scheduler #(.GRANTS_PER_FRAME(1)) dut1 (
    .clk_in      (clk_in),
    .i_rst       (i_rst),
    .req_valid   (req_valid),
    .req_player  (req_player),
    .req_incDec  (req_incDec),
    .req_step    (req_step),
    .frame_start (frame_start),
    .bar_strobe  (bar_strobe1),
    .bar_incDec  (bar_incDec1),
    .bar_coordY  (bar_coordY1),
    .pending     (pending1),
    .busy        (busy1)
`ifdef MOVE_STATS_EN
    ,
    .issued_cnt0 (issued_cnt0_b),
    .issued_cnt1 (issued_cnt1_b),
    .merged_cnt  (merged_cnt_b)
`endif
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic p, input logic dir, input int unsigned step);
    req_valid  = 1'b1;
    req_player = p;
    req_incDec = dir;
    req_step   = STEP_W'(step);
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_idle1(input string tag);
    int n = 0;
    while (busy1 && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy1), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; req_valid = 1'b0; req_player = 1'b0; req_incDec = 1'b0;
    req_step = '0; frame_start = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    chk("rst_strobe", 32'(bar_strobe), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_coordY", 32'(bar_coordY), 32'd0);
    chk("rst_incDec", 32'(bar_incDec), 32'd0);

    // zero step is ignored
    req(1'b0, 1'b1, 0);
    chk("zero_step_pending", 32'(pending), 32'd0);

    // single request, latency frame t -> strobe t+2
    req(1'b0, 1'b1, 10);
    chk("t1_pending", 32'(pending), 32'h1);
    frame();
    chk("t1_arb_strobe", 32'(bar_strobe), 32'd0);
    chk("t1_arb_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_strobe", 32'(bar_strobe), 32'h1);
    chk("t1_incDec", 32'(bar_incDec), 32'd1);
    chk("t1_coordY", 32'(bar_coordY), 32'd10);
    chk("t1_pending_after", 32'(pending), 32'd0);
    tick();
    chk("t1_settle_strobe", 32'(bar_strobe), 32'd0);
    chk("t1_hold_coordY", 32'(bar_coordY), 32'd10);
    wait_idle("t1_idle");

    // merge saturates at 40
    req(1'b0, 1'b1, 30);
    req(1'b0, 1'b1, 25);
    frame();
    tick();
    chk("t2_strobe", 32'(bar_strobe), 32'h1);
    chk("t2_coordY_sat", 32'(bar_coordY), 32'd40);
    wait_idle("t2_idle");

    // opposite direction replaces; request during ARB refills the cleared slot
    req(1'b1, 1'b0, 5);
    req(1'b1, 1'b1, 7);
    frame();
    req(1'b1, 1'b0, 3);
    chk("t3_strobe", 32'(bar_strobe), 32'h2);
    chk("t3_incDec", 32'(bar_incDec), 32'd1);
    chk("t3_coordY", 32'(bar_coordY), 32'd7);
    chk("t3_refill_pending", 32'(pending), 32'h2);
    repeat (6) tick();
    chk("t3_second_strobe", 32'(bar_strobe), 32'h2);
    chk("t3_second_incDec", 32'(bar_incDec), 32'd0);
    chk("t3_second_coordY", 32'(bar_coordY), 32'd3);
    wait_idle("t3_idle");

    // both pending: 01 at t+2, 10 at t+8
    req(1'b0, 1'b0, 3);
    req(1'b1, 1'b1, 4);
    frame();
    tick();
    chk("t4_first_strobe", 32'(bar_strobe), 32'h1);
    chk("t4_first_coordY", 32'(bar_coordY), 32'd3);
    repeat (3) tick();
    chk("t4_settle_strobe", 32'(bar_strobe), 32'd0);
    repeat (2) tick();
    chk("t4_arb_strobe", 32'(bar_strobe), 32'd0);
    tick();
    chk("t4_second_strobe", 32'(bar_strobe), 32'h2);
    chk("t4_second_coordY", 32'(bar_coordY), 32'd4);
    wait_idle("t4_idle");
    req(1'b0, 1'b1, 6);
    req(1'b1, 1'b0, 8);
    frame();
    tick();
    chk("t4_next_frame_strobe", 32'(bar_strobe), 32'h1);
    chk("t4_next_frame_coordY", 32'(bar_coordY), 32'd6);
    wait_idle("t4_next_idle");

    // one grant per frame; frame_start during SETTLE is ignored
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    req(1'b0, 1'b1, 2);
    req(1'b1, 1'b1, 9);
    frame();
    tick();
    chk("g1_strobe", 32'(bar_strobe1), 32'h1);
    chk("g1_coordY", 32'(bar_coordY1), 32'd2);
    tick();
    frame();
    wait_idle1("g1_idle");
    chk("g1_p1_waits", 32'(pending1), 32'h2);
    frame();
    tick();
    chk("g1_next_strobe", 32'(bar_strobe1), 32'h2);
    chk("g1_next_incDec", 32'(bar_incDec1), 32'd1);
    chk("g1_next_coordY", 32'(bar_coordY1), 32'd9);
    wait_idle1("g1_next_idle");
    wait_idle("g1_dut_idle");

    // reset in SETTLE with p1 pending aborts everything
    req(1'b0, 1'b0, 1);
    req(1'b1, 1'b0, 2);
    frame();
    tick();
    chk("r_strobe_before", 32'(bar_strobe), 32'h1);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_pending", 32'(pending), 32'd0);
    chk("r_strobe", 32'(bar_strobe), 32'd0);
    frame();
    tick();
    chk("r_no_strobe_t2", 32'(bar_strobe), 32'd0);
    tick();
    chk("r_no_strobe_t3", 32'(bar_strobe), 32'd0);
    chk("r_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
